// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-port ALU arbiter: opcode encodings, FSM state
// encoding and the opcode legality check.
package alu_arb_pkg;

    localparam int unsigned ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] OP_ADD  = 4'b0010;
    localparam logic [ALU_OP_W-1:0] OP_SUB  = 4'b0011;
    localparam logic [ALU_OP_W-1:0] OP_AND  = 4'b0100;
    localparam logic [ALU_OP_W-1:0] OP_OR   = 4'b0101;
    localparam logic [ALU_OP_W-1:0] OP_XOR  = 4'b0110;
    localparam logic [ALU_OP_W-1:0] OP_NOT  = 4'b0111;
    localparam logic [ALU_OP_W-1:0] OP_SLL  = 4'b1000;
    localparam logic [ALU_OP_W-1:0] OP_SRL  = 4'b1001;
    localparam logic [ALU_OP_W-1:0] OP_NOR  = 4'b1010;
    localparam logic [ALU_OP_W-1:0] OP_SUBU = 4'b1011;
    localparam logic [ALU_OP_W-1:0] OP_ADDU = 4'b1100;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StCapt = 2'd2
    } state_e;

    function automatic logic is_legal_op(input logic [ALU_OP_W-1:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT,
            OP_SLL, OP_SRL, OP_NOR, OP_SUBU, OP_ADDU: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
//   req0_i, req1_i : request lines
//   last_grant_i   : port granted most recently (0 or 1)
//   gnt_o          : one-hot grant, all-zero when nothing requests
module rr_arb2 (
    input  logic       req0_i,
    input  logic       req1_i,
    input  logic       last_grant_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = {req1_i, req0_i};
        // On contention the port that did not win last time goes next.
        if (req0_i && req1_i) begin
            gnt_o = last_grant_i ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered (one-cycle) ALU between two requesters.
//   req_*_0/1  : valid/ready request channels (opcode, operands, shift amount)
//   rsp_*_0/1  : one-cycle response pulse plus held result/flags/error
//   alu_*      : registered drive to the ALU and its registered result/flags
//   busy       : an operation is in flight
// One op in flight; handshake in cycle T gives rsp_valid in cycle T+3.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OP_W   = 4,
    parameter int unsigned SH_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid_0,
    input  logic              req_valid_1,
    output logic              req_ready_0,
    output logic              req_ready_1,
    input  logic [OP_W-1:0]   req_op_0,
    input  logic [OP_W-1:0]   req_op_1,
    input  logic [DATA_W-1:0] req_a_0,
    input  logic [DATA_W-1:0] req_a_1,
    input  logic [DATA_W-1:0] req_b_0,
    input  logic [DATA_W-1:0] req_b_1,
    input  logic [SH_W-1:0]   req_shamt_0,
    input  logic [SH_W-1:0]   req_shamt_1,
    output logic              rsp_valid_0,
    output logic              rsp_valid_1,
    output logic [DATA_W-1:0] rsp_result_0,
    output logic [DATA_W-1:0] rsp_result_1,
    output logic              rsp_overflow_0,
    output logic              rsp_overflow_1,
    output logic              rsp_zero_0,
    output logic              rsp_zero_1,
    output logic              rsp_less_0,
    output logic              rsp_less_1,
    output logic              rsp_err_0,
    output logic              rsp_err_1,
    output logic [OP_W-1:0]   alu_control,
    output logic [DATA_W-1:0] alu_operand_a,
    output logic [DATA_W-1:0] alu_operand_b,
    output logic [SH_W-1:0]   alu_shamt,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_overflow,
    input  logic              alu_zero,
    input  logic              alu_less,
    output logic              busy
);

    state_e state_q, state_d;
    logic   last_grant_q;
    logic   port_q;
    logic   illegal_q;
    logic [1:0] gnt;

    logic [OP_W-1:0]   alu_control_q;
    logic [DATA_W-1:0] alu_operand_a_q, alu_operand_b_q;
    logic [SH_W-1:0]   alu_shamt_q;

    logic              rsp_valid_0_q, rsp_valid_1_q;
    logic [DATA_W-1:0] rsp_result_0_q, rsp_result_1_q;
    logic              rsp_overflow_0_q, rsp_overflow_1_q;
    logic              rsp_zero_0_q, rsp_zero_1_q;
    logic              rsp_less_0_q, rsp_less_1_q;
    logic              rsp_err_0_q, rsp_err_1_q;

    rr_arb2 u_rr_arb2 (
        .req0_i      (req_valid_0),
        .req1_i      (req_valid_1),
        .last_grant_i(last_grant_q),
        .gnt_o       (gnt)
    );

    logic              idle;
    logic              hs;
    logic              win;
    logic [OP_W-1:0]   sel_op;
    logic [DATA_W-1:0] sel_a, sel_b;
    logic [SH_W-1:0]   sel_shamt;
    logic              sel_legal;

    assign idle        = (state_q == StIdle);
    assign req_ready_0 = idle & gnt[0];
    assign req_ready_1 = idle & gnt[1];
    assign hs          = req_ready_0 | req_ready_1;
    assign win         = gnt[1];
    assign sel_op      = win ? req_op_1    : req_op_0;
    assign sel_a       = win ? req_a_1     : req_a_0;
    assign sel_b       = win ? req_b_1     : req_b_0;
    assign sel_shamt   = win ? req_shamt_1 : req_shamt_0;
    assign sel_legal   = is_legal_op(sel_op);

    // Illegal ops never reach the ALU, so their response is synthesised here.
    logic [DATA_W-1:0] cap_result;
    logic              cap_overflow, cap_zero, cap_less;
    assign cap_result   = illegal_q ? '0 : alu_result;
    assign cap_overflow = ~illegal_q & alu_overflow;
    assign cap_zero     = illegal_q | alu_zero;
    assign cap_less     = ~illegal_q & alu_less;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (hs) state_d = StExec;
            StExec:  state_d = StCapt;
            StCapt:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q     <= 1'b1;
            port_q           <= 1'b0;
            illegal_q        <= 1'b0;
            alu_control_q    <= '0;
            alu_operand_a_q  <= '0;
            alu_operand_b_q  <= '0;
            alu_shamt_q      <= '0;
            rsp_valid_0_q    <= 1'b0;
            rsp_valid_1_q    <= 1'b0;
            rsp_result_0_q   <= '0;
            rsp_result_1_q   <= '0;
            rsp_overflow_0_q <= 1'b0;
            rsp_overflow_1_q <= 1'b0;
            rsp_zero_0_q     <= 1'b0;
            rsp_zero_1_q     <= 1'b0;
            rsp_less_0_q     <= 1'b0;
            rsp_less_1_q     <= 1'b0;
            rsp_err_0_q      <= 1'b0;
            rsp_err_1_q      <= 1'b0;
        end else begin
            rsp_valid_0_q <= 1'b0;
            rsp_valid_1_q <= 1'b0;
            if (hs) begin
                port_q       <= win;
                illegal_q    <= ~sel_legal;
                last_grant_q <= win;
                // Drive registers keep the last legal op when an illegal one arrives.
                if (sel_legal) begin
                    alu_control_q   <= sel_op;
                    alu_operand_a_q <= sel_a;
                    alu_operand_b_q <= sel_b;
                    alu_shamt_q     <= sel_shamt;
                end
            end
            if (state_q == StCapt) begin
                if (!port_q) begin
                    rsp_valid_0_q    <= 1'b1;
                    rsp_result_0_q   <= cap_result;
                    rsp_overflow_0_q <= cap_overflow;
                    rsp_zero_0_q     <= cap_zero;
                    rsp_less_0_q     <= cap_less;
                    rsp_err_0_q      <= illegal_q;
                end else begin
                    rsp_valid_1_q    <= 1'b1;
                    rsp_result_1_q   <= cap_result;
                    rsp_overflow_1_q <= cap_overflow;
                    rsp_zero_1_q     <= cap_zero;
                    rsp_less_1_q     <= cap_less;
                    rsp_err_1_q      <= illegal_q;
                end
            end
        end
    end

    assign alu_control    = alu_control_q;
    assign alu_operand_a  = alu_operand_a_q;
    assign alu_operand_b  = alu_operand_b_q;
    assign alu_shamt      = alu_shamt_q;
    assign rsp_valid_0    = rsp_valid_0_q;
    assign rsp_valid_1    = rsp_valid_1_q;
    assign rsp_result_0   = rsp_result_0_q;
    assign rsp_result_1   = rsp_result_1_q;
    assign rsp_overflow_0 = rsp_overflow_0_q;
    assign rsp_overflow_1 = rsp_overflow_1_q;
    assign rsp_zero_0     = rsp_zero_0_q;
    assign rsp_zero_1     = rsp_zero_1_q;
    assign rsp_less_0     = rsp_less_0_q;
    assign rsp_less_1     = rsp_less_1_q;
    assign rsp_err_0      = rsp_err_0_q;
    assign rsp_err_1      = rsp_err_1_q;
    assign busy           = ~idle;

endmodule
